// File: rtl/instr_pkg.sv
// Shared definitions for the program sequencer and the CPU instruction decoder.
// Instruction word layout is {opcode[11:8], data[7:0]}.
package instr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [3:0]  OPC_HALT     = 4'hF;
  localparam logic [11:0] NOP_WORD_DEF = 12'h000;

  localparam int OPC_MSB  = 11;
  localparam int OPC_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  function automatic logic is_halt(input logic [11:0] word);
    return (word[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write, registered read. A write to the address
// being read is forwarded so the fresh word is visible on the next cycle.
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Memory array write and registered read with write-through forwarding
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Issues a host-loaded program to the mini CPU one word per clock and
// captures the CPU result/overflow behind each issued word.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter logic [11:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic          Clock,
  input  logic          CLR_n,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [11:0]   WrData,
  input  logic [AW:0]   Len,
  input  logic          Start,
  input  logic          Stop,
  input  logic [7:0]    CpuOut,
  input  logic          CpuOv,
  output logic [11:0]   In,
  output logic          Valid,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Done,
  output logic [7:0]    Result,
  output logic          OvSticky
);

  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEN_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PC_ZERO  = AW'(0);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);
  localparam logic [AW-1:0] PC_TWO   = AW'(2);

  seq_state_e    state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s, raddr_s;
  logic [11:0]   in_r, in_nxt_s, rdata_s;
  logic          valid_r, valid_nxt_s, busy_r, done_r, ovsticky_r;
  logic          we_s, start_s, last_s;
  logic [7:0]    result_r;
  logic [AW:0]   len_eff_s;

  // The RAM always holds the word after the one on In (prefetch), so
  // raddr tracks the next PC plus one.
  prog_ram #(.DEPTH(DEPTH), .AW(AW), .W(12)) u_prog_ram (
    .clk  (Clock),
    .we   (we_s),
    .waddr(WrAddr),
    .wdata(WrData),
    .raddr(raddr_s),
    .rdata(rdata_s)
  );

  // Clamp the program length to the memory depth
  always_comb begin
    if (Len > LEN_MAX) begin
      len_eff_s = LEN_MAX;
    end else begin
      len_eff_s = Len;
    end
  end

  assign last_s = ({1'b0, pc_r} == (len_eff_s - LEN_ONE));

  // Next-state, next-output and RAM control decode
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    in_nxt_s    = NOP_WORD;
    valid_nxt_s = 1'b0;
    raddr_s     = PC_ZERO;
    we_s        = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        we_s = WrEn;
        if (Start && !WrEn) begin
          start_s  = 1'b1;
          pc_nxt_s = PC_ZERO;
          if (len_eff_s == LEN_ZERO) begin
            state_nxt_s = DONE;
          end else if (is_halt(rdata_s)) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
            in_nxt_s    = rdata_s;
            valid_nxt_s = 1'b1;
            raddr_s     = PC_ONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (Stop || last_s || is_halt(rdata_s)) begin
          state_nxt_s = DRAIN;
        end else begin
          pc_nxt_s    = pc_r + PC_ONE;
          in_nxt_s    = rdata_s;
          valid_nxt_s = 1'b1;
          raddr_s     = pc_r + PC_TWO;
        end
      end
      DRAIN:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered issue/status outputs
  always_ff @(posedge Clock) begin
    if (!CLR_n) begin
      state_r <= IDLE;
      pc_r    <= PC_ZERO;
      in_r    <= NOP_WORD;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      in_r    <= in_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Capture CPU result behind every issued word; a Start clears it
  always_ff @(posedge Clock) begin
    if (!CLR_n) begin
      result_r   <= 8'h00;
      ovsticky_r <= 1'b0;
    end else if (start_s) begin
      result_r   <= 8'h00;
      ovsticky_r <= 1'b0;
    end else if (valid_r) begin
      result_r   <= CpuOut;
      ovsticky_r <= ovsticky_r | CpuOv;
    end else begin
      result_r   <= result_r;
      ovsticky_r <= ovsticky_r;
    end
  end

  assign In       = in_r;
  assign Valid    = valid_r;
  assign PC       = pc_r;
  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Result   = result_r;
  assign OvSticky = ovsticky_r;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer sitting directly upstream of the mini CPU. Holds a 16-word program of 12-bit instruction words ({opcode[11:8], data[7:0]}), loaded by a host. On Start it issues one word per clock on the CPU's 12-bit instruction input. It captures the CPU's ALU result and overflow after each issued word, and raises a one-cycle Done pulse when the program ends.

## Interface
Parameters:
- DEPTH, 16, program memory words (power of two)
- AW, 4, address width, log2(DEPTH)
- NOP_WORD, 12'h000, word driven on In whenever no instruction is issued

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- CLR_n  in  1  reset, synchronous, active-low
- WrEn  in  1  program write strobe, honoured only in IDLE
- WrAddr  in  AW  program write address
- WrData  in  12  program word
- Len  in  AW+1  program length, 0..DEPTH; values above DEPTH are treated as DEPTH
- Start  in  1  begin execution, honoured only in IDLE with WrEn=0
- Stop  in  1  abort request, honoured in RUN
- CpuOut  in  8  CPU ALU result (combinational from CPU registers)
- CpuOv  in  1  CPU overflow flag
- In  out  12  registered instruction word to CPU
- Valid  out  1  In carries an issued program word this cycle
- PC  out  AW  address of the word currently on In
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  one-cycle pulse at end of program
- Result  out  8  last captured CpuOut
- OvSticky  out  1  OR of CpuOv over all captures since Start

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - In=NOP_WORD, Valid=0.
  - WrEn writes mem[WrAddr]<=WrData.
  - Start with WrEn=0 and Len≠0 → RUN: PC=0, In=mem[0], Valid=1; Result and OvSticky cleared.
  - Start with Len=0 → DONE directly, with no issue.
  - Start together with WrEn: the write is performed and Start is ignored.
- RUN:
  - Each cycle issues mem[PC], then PC increments.
  - A fetched word with opcode 4'hF is a HALT marker. It is not issued: In=NOP_WORD, Valid=0, → DRAIN.
  - After the word at PC=Len-1 is issued → DRAIN.
  - Stop → DRAIN in the next cycle; the word on In during the Stop cycle still counts as issued.
  - WrEn and Start are ignored.
- Capture: in every cycle following a Valid cycle, Result<=CpuOut and OvSticky<=OvSticky|CpuOv. This reflects the CPU register state after the issued word's edge.
- DRAIN: one cycle. In=NOP_WORD, Valid=0, final capture taken. → DONE.
- DONE: one cycle. Done=1, Busy=0. → IDLE.
- PC wrap: with Len=DEPTH, PC reaches DEPTH-1 and ends the run; it never wraps to 0 while in RUN.
- Memory contents are not cleared by CLR_n.

## Timing
- Reset (CLR_n=0 at an edge): state=IDLE, In=NOP_WORD, Valid=0, PC=0, Busy=0, Done=0, Result=8'h00, OvSticky=0.
- Reset mid-RUN aborts immediately; no Done pulse.
- Start sampled at edge t: In/Valid show word 0 after t, and word k after t+k.
- Capture of word k occurs at edge t+k+1.
- Length-N program with no HALT and no Stop:
  - Valid high N cycles.
  - DRAIN cycle after the last issue.
  - Done high in the cycle after DRAIN, i.e. N+2 cycles after Start.
  - Busy high N+1 cycles.
- Memory read is registered. A write in IDLE is visible to any later Start.

## Structure
- Shared package instr_pkg:
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - OPC_HALT=4'hF.
  - NOP_WORD default.
  - Instruction field slices OPC_MSB/LSB and DATA_MSB/LSB, also used by the CPU's instruction decoder.
- One natural sub-module, prog_ram: DEPTH×12 synchronous-write, registered-read memory.
- FSM, PC, and capture logic stay in instr_sequencer.

## Test plan
- Reset, then load mem[0]=12'h1_05, mem[1]=12'h2_03 with Len=2, then Start.
  - Required: In=12'h105 then 12'h203, Valid high 2 cycles.
  - Done pulses 4 cycles after Start; PC sequence 0,1.
- Program with a HALT word: mem[2]=12'hF00, Len=5.
  - Required: words 0 and 1 issued, Valid=0 at the HALT slot.
  - DRAIN, then Done; words 3 and 4 never appear.
- Stop asserted on the second issue cycle of an 8-word program.
  - Required: exactly 2 words issued, then DRAIN and Done.
  - Result equals CpuOut sampled after the second word.
- Capture and overflow: drive CpuOut=8'hA5 with CpuOv=1 after word 0, and CpuOv=0 afterwards.
  - Required: Result follows the last capture; OvSticky stays 1 until the next Start clears it.
- Len=0 Start: Done pulses in the next cycle with Valid never high.
  - Len=16: PC runs 0..15 with no wrap.
  - Len=20: behaves as Len=16.
- Boundaries:
  - CLR_n low mid-RUN: outputs go to reset values at that edge, with no Done.
  - WrEn together with Start in IDLE: the write lands and Start is ignored.
  - WrEn during RUN: memory is unchanged.
